// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the multicycle RISC-V controller: FSM states, opcodes,
// datapath select encodings and the per-state control vector.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10} result_src_t;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
  } alu_control_t;

  // Which ALU operation a state asks for; DECODED defers to the alu_decoder.
  typedef enum logic [1:0] {ALUSEL_ADD, ALUSEL_SUB, ALUSEL_DECODED} alu_sel_t;

  typedef struct packed {
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        pc_update;
    logic        branch;
    result_src_t result_src;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_sel_t    alu_sel;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_sel   = ALUSEL_DECODED;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_sel   = ALUSEL_DECODED;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_sel   = ALUSEL_SUB;
        c.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal_op;

  modport master (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_op
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_op
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5/op to the ALU operation for R-type and I-type ALU instructions.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]   i_op,
  input  logic [2:0]   i_funct3,
  input  logic         i_funct7b5,
  output alu_control_t o_alu_control
);

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    o_alu_control = ALU_ADD;
    case (i_funct3)
      3'b000:  if (i_op == OP_RTYPE && i_funct7b5) o_alu_control = ALU_SUB;
      3'b010:  o_alu_control = ALU_SLT;
      3'b110:  o_alu_control = ALU_OR;
      3'b111:  o_alu_control = ALU_AND;
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM controller for a multicycle RISC-V datapath (lw, sw, R/I ALU, jal, beq).
// Control outputs are registered from the next state so they align with the state register.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.slave   bus
);

  state_t       r_state;
  state_t       w_next;
  ctrl_t        r_ctrl;
  alu_control_t w_dec_alu;
  alu_control_t w_alu_control;
  imm_src_t     w_imm_src;

  alu_decoder u_alu_decoder (
    .i_op          (bus.op),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .o_alu_control (w_dec_alu)
  );

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_JAL:            w_next = S_JAL;
          OP_BEQ:            w_next = S_BEQ;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR:                  w_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:                 w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL:   w_next = S_ALUWB;
      default:                   w_next = S_FETCH;
    endcase
  end

  // Reset loads FETCH selects; enables that are 1 in FETCH are masked by rst below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep state and outputs updating together at the edge.
      r_state <= S_FETCH;
      r_ctrl  <= state_ctrl(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
    end
  end

  always_comb begin
    case (bus.op)
      OP_STORE: w_imm_src = IMM_S;
      OP_BEQ:   w_imm_src = IMM_B;
      OP_JAL:   w_imm_src = IMM_J;
      default:  w_imm_src = IMM_I;
    endcase
  end

  always_comb begin
    case (r_ctrl.alu_sel)
      ALUSEL_SUB:     w_alu_control = ALU_SUB;
      ALUSEL_DECODED: w_alu_control = w_dec_alu;
      default:        w_alu_control = ALU_ADD;
    endcase
  end

  assign bus.pc_write    = ~rst & (r_ctrl.pc_update | (r_ctrl.branch & bus.zero));
  assign bus.ir_write    = ~rst & r_ctrl.ir_write;
  assign bus.mem_write   = ~rst & r_ctrl.mem_write;
  assign bus.reg_write   = ~rst & r_ctrl.reg_write;
  assign bus.illegal_op  = ~rst & (r_state == S_DECODE) & (w_next == S_FETCH);
  assign bus.adr_src     = r_ctrl.adr_src;
  assign bus.result_src  = r_ctrl.result_src;
  assign bus.alu_src_a   = r_ctrl.alu_src_a;
  assign bus.alu_src_b   = r_ctrl.alu_src_b;
  assign bus.imm_src     = w_imm_src;
  assign bus.alu_control = w_alu_control;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle outputs of each instruction
// are compared against a cycle-indexed model built from the instruction tables.
module tb_multicycle_ctrl;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_op;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] imm_of(logic [6:0] op);
    case (op)
      SW:      return 2'b01;
      BEQ:     return 2'b10;
      JAL:     return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [6:0] op, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int len_of(logic [6:0] op);
    case (op)
      LW:              return 5;
      SW, RT, IT, JAL: return 4;
      BEQ:             return 3;
      default:         return 2;
    endcase
  endfunction

  // Expected outputs during cycle k (0 = first cycle) of an instruction.
  function automatic vec_t model(logic [6:0] op, logic [2:0] f3, logic f7, logic z, int k);
    vec_t v;
    v = '0;
    v.imm_src = imm_of(op);
    if (k == 0) begin
      v.ir_write = 1; v.alu_src_b = 2'b10; v.result_src = 2'b10; v.pc_write = 1;
    end else if (k == 1) begin
      v.alu_src_a = 2'b01; v.alu_src_b = 2'b01; v.illegal_op = (len_of(op) == 2);
    end else begin
      case (op)
        LW, SW: begin
          if (k == 2) begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b01; end
          else if (k == 3 && op == LW) v.adr_src = 1;
          else if (k == 3) begin v.adr_src = 1; v.mem_write = 1; end
          else begin v.result_src = 2'b01; v.reg_write = 1; end
        end
        RT, IT: begin
          if (k == 2) begin
            v.alu_src_a = 2'b10; v.alu_src_b = (op == IT) ? 2'b01 : 2'b00;
            v.alu_control = alu_of(op, f3, f7);
          end else v.reg_write = 1;
        end
        JAL: begin
          if (k == 2) begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.pc_write = 1; end
          else v.reg_write = 1;
        end
        BEQ: begin
          v.alu_src_a = 2'b10; v.alu_control = 3'b001; v.pc_write = z;
        end
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  function automatic vec_t reset_vec(logic [6:0] op);
    vec_t v;
    v = '0;
    v.result_src = 2'b10;
    v.alu_src_b  = 2'b10;
    v.imm_src    = imm_of(op);
    return v;
  endfunction

  function automatic vec_t sample();
    vec_t v;
    v = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
         bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
         bus.alu_control, bus.illegal_op};
    return v;
  endfunction

  // Drives one instruction starting in its FETCH cycle; zmode 0/1 forces zero, 2 randomizes.
  // Stops at the negedge of cycle stop_at when stop_at >= 0.
  task automatic drive_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int zmode, input int stop_at);
    vec_t act, exp_v;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
    for (int k = 0; k < len_of(op); k++) begin
      bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      exp_v = model(op, f3, f7, bus.zero, k);
      act   = sample();
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL %s cycle %0d op=%b f3=%b f7=%b: got %h expected %h",
                 name, k, op, f3, f7, act, exp_v);
      end
      if (k == stop_at) return;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    vec_t act;
    bus.op = SW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b1;
    rst = 1'b1;
    #12;
    act = sample();
    n_cmp++;
    if (act !== reset_vec(SW)) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", act, reset_vec(SW));
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    drive_instr("lw", LW, 3'b010, 1'b0, 2, -1);
  endtask

  task automatic test_sw();
    drive_instr("sw", SW, 3'b010, 1'b0, 2, -1);
  endtask

  task automatic test_rtype();
    drive_instr("r_sub", RT, 3'b000, 1'b1, 2, -1);
    drive_instr("r_add", RT, 3'b000, 1'b0, 2, -1);
    drive_instr("i_addi_f7", IT, 3'b000, 1'b1, 2, -1);
    drive_instr("r_or", RT, 3'b110, 1'b0, 2, -1);
  endtask

  task automatic test_jal();
    drive_instr("jal", JAL, 3'b000, 1'b0, 2, -1);
  endtask

  task automatic test_beq();
    drive_instr("beq_taken", BEQ, 3'b000, 1'b0, 1, -1);
    drive_instr("beq_not_taken", BEQ, 3'b000, 1'b0, 0, -1);
  endtask

  task automatic test_illegal();
    drive_instr("illegal", 7'b1111111, 3'b000, 1'b0, 2, -1);
    drive_instr("after_illegal", LW, 3'b010, 1'b0, 2, -1);
  endtask

  task automatic test_reset_mid_memwrite();
    vec_t act;
    drive_instr("sw_abort", SW, 3'b010, 1'b0, 2, 3);
    #2;
    rst = 1'b1;
    #1;
    act = sample();
    n_cmp++;
    if (act !== reset_vec(SW)) begin
      n_err++;
      $display("FAIL reset_mid_memwrite: got %h expected %h", act, reset_vec(SW));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_instr("after_abort", RT, 3'b111, 1'b0, 2, -1);
  endtask

  task automatic test_random();
    logic [6:0] op;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 6))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = IT;
        4: op = JAL;
        5: op = BEQ;
        default: begin
          op = 7'($urandom);
          if (len_of(op) != 2) op = 7'b1111111;
        end
      endcase
      drive_instr("random", op, 3'($urandom), 1'($urandom), 2, -1);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_jal();
    test_beq();
    test_illegal();
    test_reset_mid_memwrite();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-002 The ports SHALL be:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- op, input, 7, instruction opcode from IR.
- funct3, input, 3, instruction funct3.
- funct7b5, input, 1, instruction bit 30.
- zero, input, 1, ALU zero flag.
- pc_write, output, 1, PC register enable.
- adr_src, output, 1, memory address select: 0=PC, 1=ALUOut.
- mem_write, output, 1, data memory write enable.
- ir_write, output, 1, IR/OldPC enable.
- reg_write, output, 1, register file write enable.
- result_src, output, 2, result select: 00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a, output, 2, ALU A select: 00=PC, 01=OldPC, 10=RD1.
- alu_src_b, output, 2, ALU B select: 00=RD2, 01=ImmExt, 10=constant 4.
- imm_src, output, 2, immediate-extend format: 00=I, 01=S, 10=B, 11=J.
- alu_control, output, 3, ALU op: 000=add, 001=sub, 010=and, 011=or, 101=slt.
- illegal_op, output, 1, one-cycle pulse on an unsupported opcode.

Function
REQ-003 The FSM SHALL be Moore-style with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ.
REQ-004 Transitions SHALL be:
- FETCH->DECODE.
- DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1101111->JAL; 1100011->BEQ; any other->FETCH.
- MEMADR->MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD->MEMWB->FETCH.
- MEMWRITE->FETCH.
- EXECR, EXECI and JAL->ALUWB->FETCH.
- BEQ->FETCH.
REQ-005 Any output not listed for a state SHALL be 0. Per-state outputs SHALL be:
- FETCH: ir_write=1, alu_src_b=10, add, result_src=10, pc_update=1.
- DECODE: alu_src_a=01, alu_src_b=01, add.
- MEMADR: alu_src_a=10, alu_src_b=01, add.
- MEMREAD: adr_src=1, result_src=00.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECR: alu_src_a=10, alu_src_b=00, decoded op.
- EXECI: alu_src_a=10, alu_src_b=01, decoded op.
- ALUWB: result_src=00, reg_write=1.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_update=1.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, branch=1.
REQ-006 pc_write SHALL equal pc_update OR (branch AND zero), evaluated combinationally in the same cycle.
REQ-007 imm_src SHALL be decoded combinationally from op, independent of state: 0100011->01, 1100011->10, 1101111->11, all others->00.
REQ-008 The decoded ALU op SHALL be:
- funct3=000: sub if op=0110011 and funct7b5=1, else add.
- funct3=010: slt.
- funct3=110: or.
- funct3=111: and.
- any other funct3: add.
REQ-009 illegal_op SHALL be 1 for exactly the DECODE cycle that takes the "any other" exit.
REQ-010 Each instruction SHALL take these cycle counts: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3, illegal 2.

Reset
REQ-011 rst=1 SHALL force the state to FETCH asynchronously.
REQ-012 While rst=1, pc_write, ir_write, mem_write, reg_write and illegal_op SHALL be 0; all select outputs SHALL hold their FETCH values.
REQ-013 The first rising edge after rst deasserts SHALL execute FETCH.
REQ-014 Reset asserted in any state SHALL abort the instruction with no further write enables.

Structure
REQ-015 A shared package riscv_ctrl_pkg SHALL hold:
- the state enum;
- the opcode constants;
- the result_src, alu_src_a, alu_src_b, imm_src and alu_control encodings.
REQ-016 The funct3/funct7b5/op-to-alu_control logic SHALL be a separate sub-module, alu_decoder, instantiated once.

Verification
REQ-017 lw (op=0000011, funct3=010): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 with result_src=01 only in MEMWB; imm_src=00 throughout.
REQ-018 sw (op=0100011): mem_write=1 and adr_src=1 only in the 4th cycle; imm_src=01; reg_write never 1.
REQ-019 R-type sub (funct3=000, funct7b5=1): alu_control=001 in EXECR; with funct7b5=0, alu_control=000.
REQ-020 beq (op=1100011, imm_src=10):
- zero=1 in BEQ cycle: pc_write=1.
- zero=0 in BEQ cycle: pc_write=0.
- Either case: next state FETCH.
REQ-021 op=1111111: illegal_op pulses for 1 cycle in DECODE, next state FETCH, no write enable asserted after FETCH.
REQ-022 rst asserted mid-MEMWRITE: state becomes FETCH immediately and mem_write drops to 0 in the same cycle, before the clock edge.
